// File: rtl/trace_pkg.sv
// trace_pkg -- shared types and constants for the commit trace buffer.
//   trace_entry_t : one retired-instruction record (pc, instruction, rd, data)
//   NOP_INSN      : canonical NOP encoding (addi x0,x0,0)
//   *_W           : field widths
package trace_pkg;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned DATA_W = 64;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INSN_W-1:0] instruction;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } trace_entry_t;

    function automatic logic is_nop(input logic [INSN_W-1:0] insn);
        return insn == NOP_INSN;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if -- trace producer / consumer signal bundle.
//   Producer side : trace_valid, pc, instruction, rd, WriteData
//   Consumer side : out_ready (in), out_valid, out_pc, out_instruction,
//                   out_rd, out_data (out)
//   modport master : the environment (drives trace entries and out_ready)
//   modport slave  : the buffer
interface commit_trace_buffer_if;
    import trace_pkg::*;

    logic              trace_valid;
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] instruction;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] WriteData;

    logic              out_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INSN_W-1:0] out_instruction;
    logic [RD_W-1:0]   out_rd;
    logic [DATA_W-1:0] out_data;

    modport master (
        output trace_valid, pc, instruction, rd, WriteData, out_ready,
        input  out_valid, out_pc, out_instruction, out_rd, out_data
    );

    modport slave (
        input  trace_valid, pc, instruction, rd, WriteData, out_ready,
        output out_valid, out_pc, out_instruction, out_rd, out_data
    );

endinterface

// File: rtl/trace_ram.sv
// trace_ram -- DEPTH x trace_entry_t storage, no reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address, wdata : write data
//   raddr : asynchronous read address, rdata : read data
module trace_ram
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  trace_entry_t  wdata,
    input  logic [AW-1:0] raddr,
    output trace_entry_t  rdata
);

    trace_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer -- circular FIFO of retired-instruction trace entries.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   flush      : synchronous clear of contents, overflow and drop_count
//   bus        : commit_trace_buffer_if.slave (trace in, head entry out)
//   count      : entries held
//   overflow   : sticky, set once any entry has been dropped
//   drop_count : saturating count of dropped entries
// Optional build macro TRACE_NOP_FILTER_EN: NOP retirements are ignored
// (neither stored nor counted as drops).
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    commit_trace_buffer_if.slave    bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          filtered, full, push, pop, drop;
    trace_entry_t  wr_entry, head;

`ifdef TRACE_NOP_FILTER_EN
    assign filtered = is_nop(bus.instruction);
`else
    assign filtered = 1'b0;
`endif

    assign full = (count == FULL_COUNT);
    assign pop  = bus.out_valid && bus.out_ready;
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign push = bus.trace_valid && !filtered && (!full || pop);
    assign drop = bus.trace_valid && !filtered && full && !pop;

    assign wr_entry = '{pc: bus.pc, instruction: bus.instruction,
                        rd: bus.rd, data: bus.WriteData};

    trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

    assign bus.out_valid       = (count != '0);
    assign bus.out_pc          = head.pc;
    assign bus.out_instruction = head.instruction;
    assign bus.out_rd          = head.rd;
    assign bus.out_data        = head.data;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer -- directed bench for commit_trace_buffer with a
// queue-based reference model compared on every falling clock edge.
module tb_commit_trace_buffer;
    import trace_pkg::*;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DROP_W = 8;
    localparam logic [31:0] INSN   = 32'h0010_0093;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic [3:0] count;
    logic overflow;
    logic [DROP_W-1:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    commit_trace_buffer_if bus_if();

    commit_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .bus        (bus_if),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    trace_entry_t q[$];
    logic m_ovf = 1'b0;
    int   m_drops = 0;

    function automatic logic m_filtered(input logic [31:0] insn);
`ifdef TRACE_NOP_FILTER_EN
        return insn == 32'h0000_0013;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_drops = 0;
        end else if (flush) begin
            q.delete();
            m_ovf = 1'b0;
            m_drops = 0;
        end else begin
            trace_entry_t e;
            logic did_pop;
            did_pop = (q.size() > 0) && bus_if.out_ready;
            e = '{pc: bus_if.pc, instruction: bus_if.instruction,
                  rd: bus_if.rd, data: bus_if.WriteData};
            if (did_pop) void'(q.pop_front());
            if (bus_if.trace_valid && !m_filtered(bus_if.instruction)) begin
                if (q.size() < DEPTH) q.push_back(e);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("model out_valid", 64'(bus_if.out_valid), 64'(q.size() != 0));
        cmp("model count", 64'(count), 64'(q.size()));
        cmp("model overflow", 64'(overflow), 64'(m_ovf));
        cmp("model drop_count", 64'(drop_count), 64'(m_drops));
        if (q.size() != 0) begin
            cmp("model out_pc", bus_if.out_pc, q[0].pc);
            cmp("model out_instruction", 64'(bus_if.out_instruction), 64'(q[0].instruction));
            cmp("model out_rd", 64'(bus_if.out_rd), 64'(q[0].rd));
            cmp("model out_data", bus_if.out_data, q[0].data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic tv, input logic [63:0] pcv,
                       input logic [31:0] insn, input logic rdy);
        bus_if.trace_valid = tv;
        bus_if.pc          = pcv;
        bus_if.instruction = insn;
        bus_if.rd          = pcv[6:2];
        bus_if.WriteData   = {pcv[31:0], ~pcv[31:0]};
        bus_if.out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc(1'b0, 64'h0, INSN, 1'b0);
        flush = 1'b0;
    endtask

    initial begin
        bus_if.trace_valid = 1'b0;
        bus_if.pc = '0;
        bus_if.instruction = '0;
        bus_if.rd = '0;
        bus_if.WriteData = '0;
        bus_if.out_ready = 1'b0;
        #12;
        cmp("reset out_valid", 64'(bus_if.out_valid), 64'd0);
        cmp("reset count", 64'(count), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Three pushes held, then drained in order.
        cyc(1'b1, 64'h0, INSN, 1'b0);
        cyc(1'b1, 64'h4, INSN, 1'b0);
        cyc(1'b1, 64'h8, INSN, 1'b0);
        cmp("basic count", 64'(count), 64'd3);
        cmp("basic head pc", bus_if.out_pc, 64'h0);
        cyc(1'b0, 64'h0, INSN, 1'b1);
        cmp("drain pc1", bus_if.out_pc, 64'h4);
        cyc(1'b0, 64'h0, INSN, 1'b1);
        cmp("drain pc2", bus_if.out_pc, 64'h8);
        cyc(1'b0, 64'h0, INSN, 1'b1);
        cmp("drain empty", 64'(bus_if.out_valid), 64'd0);

        // Overflow: 10 pushes into 8 slots.
        for (int i = 0; i < 10; i++) cyc(1'b1, 64'h100 + 64'(4*i), INSN, 1'b0);
        cmp("ovf count", 64'(count), 64'd8);
        cmp("ovf flag", 64'(overflow), 64'd1);
        cmp("ovf drops", 64'(drop_count), 64'd2);
        for (int i = 0; i < 8; i++) begin
            cmp("ovf drain pc", bus_if.out_pc, 64'h100 + 64'(4*i));
            cyc(1'b0, 64'h0, INSN, 1'b1);
        end
        cmp("ovf drained", 64'(bus_if.out_valid), 64'd0);
        do_flush();

        // Full buffer with simultaneous push and pop across pointer wrap.
        for (int i = 0; i < 8; i++) cyc(1'b1, 64'h200 + 64'(4*i), INSN, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'h220 + 64'(4*i), INSN, 1'b1);
        cmp("wrap count", 64'(count), 64'd8);
        cmp("wrap drops", 64'(drop_count), 64'd0);
        for (int i = 0; i < 8; i++) begin
            cmp("wrap drain pc", bus_if.out_pc, 64'h214 + 64'(4*i));
            cyc(1'b0, 64'h0, INSN, 1'b1);
        end

        // NOP filtering.
        cyc(1'b1, 64'h300, 32'h0000_0013, 1'b0);
        cyc(1'b1, 64'h304, 32'h0050_0093, 1'b0);
        cyc(1'b1, 64'h308, 32'h0000_0013, 1'b0);
`ifdef TRACE_NOP_FILTER_EN
        cmp("nop count", 64'(count), 64'd1);
        cmp("nop head insn", 64'(bus_if.out_instruction), 64'h0050_0093);
`else
        cmp("nop count", 64'(count), 64'd3);
        cmp("nop head insn", 64'(bus_if.out_instruction), 64'h0000_0013);
`endif
        do_flush();

        // Drop counter saturation, then flush.
        for (int i = 0; i < 300; i++) cyc(1'b1, 64'h1000 + 64'(4*i), INSN, 1'b0);
        cmp("sat drops", 64'(drop_count), 64'd255);
        cmp("sat ovf", 64'(overflow), 64'd1);
        do_flush();
        cmp("flush count", 64'(count), 64'd0);
        cmp("flush ovf", 64'(overflow), 64'd0);
        cmp("flush drops", 64'(drop_count), 64'd0);

        // Asynchronous reset mid-cycle with five entries held.
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'h400 + 64'(4*i), INSN, 1'b0);
        cmp("pre-reset count", 64'(count), 64'd5);
        cyc(1'b0, 64'h0, INSN, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        cmp("async reset out_valid", 64'(bus_if.out_valid), 64'd0);
        cmp("async reset count", 64'(count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bus_if.trace_valid = 1'b1;
        bus_if.pc = 64'h500;
        bus_if.rd = 5'd0;
        bus_if.WriteData = 64'h55;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        // Push into an empty buffer with out_ready high: no pop happens.
        cmp("first push count", 64'(count), 64'd1);
        cmp("first push pc", bus_if.out_pc, 64'h500);
        cyc(1'b0, 64'h0, INSN, 1'b1);
        cmp("final empty", 64'(bus_if.out_valid), 64'd0);
        cyc(1'b0, 64'h0, INSN, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
